// File: rtl/fractal_vga_pkg.sv
// fractal_vga_pkg: VGA 640x480@60 timing boundaries, frame buffer geometry and colour type
package fractal_vga_pkg;

    localparam int H_FP_START   = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;

    localparam int V_FP_START   = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;

    localparam int FB_DEPTH     = 307200;
    localparam int ADDR_W       = $clog2(FB_DEPTH);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/fractal_fb_scanout_if.sv
// fractal_fb_scanout_if: frame buffer read port plus VGA display pins
interface fractal_fb_scanout_if;
    import fractal_vga_pkg::*;

    logic              display;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] addr_r;
    logic              rd_en;
    logic              hsync;
    logic              vsync;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              frame_start;

    modport master (
        input  display, rd_data,
        output addr_r, rd_en, hsync, vsync, red, green, blue, frame_start
    );

    modport slave (
        output display, rd_data,
        input  addr_r, rd_en, hsync, vsync, red, green, blue, frame_start
    );

endinterface

// File: rtl/fb_palette.sv
// fb_palette: registered divergence-count to 12-bit colour map; FRACTAL_FB_GRAY_EN selects grayscale
module fb_palette
    import fractal_vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank,
    input  logic [7:0] k,
    output rgb_t       rgb
);
    rgb_t c;

    // count bits 5:2 carry the visible gradient; bits 7:6 wrap and are dropped
    always_comb begin
`ifdef FRACTAL_FB_GRAY_EN
        c = {k[5:2], k[5:2], k[5:2]};
`else
        c = {k[5:2], k[3:0], ~k[5:2]};
`endif
    end

    // zero count means the point never escaped: always black, as is blanking
    always_ff @(posedge clk) begin
        if (rst)
            rgb <= '0;
        else if (en)
            rgb <= (blank || k == 8'd0) ? '0 : c;
    end

endmodule

// File: rtl/fractal_fb_scanout.sv
// fractal_fb_scanout: 640x480@60 VGA scan-out of the fractal frame buffer (palette: FRACTAL_FB_GRAY_EN)
module fractal_fb_scanout
    import fractal_vga_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int RD_LATENCY = 1
) (
    input logic                  Clk_100M,
    input logic                  reset,
    fractal_fb_scanout_if.master bus
);
    if (RD_LATENCY != 1) begin : g_rd_latency_check
        $error("fractal_fb_scanout: only RD_LATENCY=1 is supported");
    end

    localparam logic [9:0] HFP = 10'(H_VISIBLE);
    localparam logic [9:0] HSS = 10'(H_VISIBLE + H_SYNC_START - H_FP_START);
    localparam logic [9:0] HSE = 10'(H_VISIBLE + H_SYNC_END - H_FP_START);
    localparam logic [9:0] HL  = 10'(H_VISIBLE + H_TOTAL - H_FP_START - 1);
    localparam logic [9:0] VFP = 10'(V_VISIBLE);
    localparam logic [9:0] VSS = 10'(V_VISIBLE + V_SYNC_START - V_FP_START);
    localparam logic [9:0] VSE = 10'(V_VISIBLE + V_SYNC_END - V_FP_START);
    localparam logic [9:0] VL  = 10'(V_VISIBLE + V_TOTAL - V_FP_START - 1);

    logic [1:0]        ph;
    logic [9:0]        h;
    logic [9:0]        v;
    logic              show;
    logic              vis;
    logic              h_last;
    logic              v_last;
    logic              in_hs;
    logic              in_vs;
    logic              first_px;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              hs_q;
    logic              vs_q;
    rgb_t              rgb;

    // raster decode; row*640 built from shifts, 640 = 512 + 128
    always_comb begin
        vis      = (h < HFP) && (v < VFP);
        h_last   = h == HL;
        v_last   = v == VL;
        in_hs    = (h >= HSS) && (h < HSE);
        in_vs    = (v >= VSS) && (v < VSE);
        first_px = (ph == 2'd0) && (h == '0) && (v == '0);
        addr_n   = (ADDR_W'(v) << 9) + (ADDR_W'(v) << 7) + ADDR_W'(h);
    end

    // pixel phase and raster position, stepping once per 4 clocks
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            ph <= '0;
            h  <= '0;
            v  <= '0;
        end else begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) begin
                h <= h_last ? '0 : h + 10'd1;
                if (h_last)
                    v <= v_last ? '0 : v + 10'd1;
            end
        end
    end

    // one RAM read per visible pixel, issued from ph0; address holds through blanking
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            addr_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= (ph == 2'd0) && vis;
            if ((ph == 2'd0) && vis)
                addr_q <= addr_n;
        end
    end

    // frame-complete flag is captured only at the top-left pixel so a frame is never torn
    always_ff @(posedge Clk_100M) begin
        if (reset)
            show <= 1'b0;
        else if (first_px)
            show <= bus.display;
    end

    // syncs registered on the same ph2 edge as colour to stay pixel-aligned
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (ph == 2'd2) begin
            hs_q <= !in_hs;
            vs_q <= !in_vs;
        end
    end

    fb_palette u_palette (
        .clk   (Clk_100M),
        .rst   (reset),
        .en    (ph == 2'd2),
        .blank (!(show && vis)),
        .k     (bus.rd_data),
        .rgb   (rgb)
    );

    assign bus.addr_r      = addr_q;
    assign bus.rd_en       = rd_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.red         = rgb.r;
    assign bus.green       = rgb.g;
    assign bus.blue        = rgb.b;
    assign bus.frame_start = first_px && !reset;

endmodule
